decimal_to_bcd_encoder: RTL and testbench

Converts ten decimal key lines (one line per digit 0–9) into 4-bit BCD codes. It is the encoding counterpart of the team's BCD-to-decimal decoder. Inputs are asynchronous key lines; the block synchronises and debounces them, validates that exactly one key is pressed, and emits one BCD digit per press. Digits are buffered in a small FIFO with a valid/ready output handshake, feeding downstream BCD logic such as the decoder or display drivers.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_fifo.sv | 54 +++++
 rtl/decimal_to_bcd_encoder.sv | 124 ++++++++++++
 tb/tb_decimal_to_bcd_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the decimal key encoder and the BCD decoder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD,
        FAULT
    } enc_state_t;

    localparam int NUM_KEYS = 10;

    function automatic bcd_digit_t onehot10_to_bcd(input logic [NUM_KEYS-1:0] v);
        bcd_digit_t d;
        d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) d = bcd_digit_t'(i);
        end
        return d;
    endfunction

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot10(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 10'd1)) == '0);
    endfunction

endpackage

// File: rtl/bcd_digit_fifo.sv
// Small power-of-two FIFO of BCD digits; head is read straight from storage.
module bcd_digit_fifo
    import bcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  bcd_digit_t                      push_data,
    input  logic                            pop,
    output bcd_digit_t                      head,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    bcd_digit_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decimal_to_bcd_encoder.sv
// Ten asynchronous key lines -> synchronised, debounced, validated BCD digits
// delivered through a valid/ready FIFO. One digit per press, no auto-repeat.
module decimal_to_bcd_encoder
    import bcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [9:0]                      dec_in,
    output logic [3:0]                      bcd_out,
    output logic                            bcd_valid,
    input  logic                            bcd_ready,
    output logic                            key_error,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]       sync_meta;
    logic [9:0]       sync_vec;
    enc_state_t       state;
    logic [9:0]       snapshot;
    logic [CNT_W-1:0] cnt;
    logic             push;
    bcd_digit_t       push_digit;
    bcd_digit_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_vec  <= '0;
        end else begin
            sync_meta <= dec_in;
            sync_vec  <= sync_meta;
        end
    end

    // cnt counts matching samples in SETTLE and consecutive zero samples in HELD/FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snapshot   <= '0;
            cnt        <= '0;
            push       <= 1'b0;
            push_digit <= '0;
            key_error  <= 1'b0;
        end else begin
            push      <= 1'b0;
            key_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_vec != '0) begin
                        state    <= SETTLE;
                        snapshot <= sync_vec;
                        cnt      <= CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (sync_vec == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (sync_vec != snapshot) begin
                        snapshot <= sync_vec;
                        cnt      <= CNT_W'(1);
                    end else if (cnt >= CNT_LAST) begin
                        cnt <= '0;
                        if (is_onehot10(snapshot)) begin
                            push       <= 1'b1;
                            push_digit <= onehot10_to_bcd(snapshot);
                            state      <= HELD;
                        end else begin
                            key_error <= 1'b1;
                            state     <= FAULT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD, FAULT: begin
                    if (sync_vec != '0) begin
                        cnt <= '0;
                    end else if (cnt >= CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop       = bcd_ready && !fifo_empty;
    assign bcd_valid = !fifo_empty;
    assign bcd_out   = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else        overflow <= push && fifo_full && !pop;
    end

    bcd_digit_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_digit),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
// Bench for decimal_to_bcd_encoder: directed corner sequences, a vector table,
// and random presses scored against a press-level reference model.
module tb_decimal_to_bcd_encoder;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [9:0]                   dec_in = '0;
    logic                         bcd_ready = 1'b0;
    logic [3:0]                   bcd_out;
    logic                         bcd_valid;
    logic                         key_error;
    logic                         overflow;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int cyc = 0;
    bit rand_ready = 0;
    logic [3:0] popped[$];

    typedef struct {
        logic [9:0] vec;
        int         hold;
        bit         exp_push;
        logic [3:0] exp_bcd;
        bit         exp_err;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    decimal_to_bcd_encoder #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_in     (dec_in),
        .bcd_out    (bcd_out),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .key_error  (key_error),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    // Observe handshakes and pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bcd_valid && bcd_ready) popped.push_back(bcd_out);
            if (key_error) err_seen++;
            if (overflow) ovf_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) bcd_ready = (cyc % 4 == 0) || ($urandom_range(0, 1) == 1);
    endtask

    task automatic press(input logic [9:0] v, input int hold, input int gap);
        dec_in = v;
        repeat (hold) step();
        dec_in = '0;
        repeat (gap) step();
    endtask

    task automatic pop_one();
        bcd_ready = 1'b1;
        step();
        bcd_ready = 1'b0;
    endtask

    initial begin
        int         n;
        int         e0;
        int         o0;
        int         exp_err;
        logic [3:0] exp_q[$];
        logic [9:0] v;
        int         h;

        tbl[0]  = '{10'h001, D,     1'b1, 4'd0, 1'b0};
        tbl[1]  = '{10'h002, D,     1'b1, 4'd1, 1'b0};
        tbl[2]  = '{10'h004, D + 5, 1'b1, 4'd2, 1'b0};
        tbl[3]  = '{10'h200, D,     1'b1, 4'd9, 1'b0};
        tbl[4]  = '{10'h100, 2 * D, 1'b1, 4'd8, 1'b0};
        tbl[5]  = '{10'h010, D - 1, 1'b0, 4'd0, 1'b0};
        tbl[6]  = '{10'h003, D,     1'b0, 4'd0, 1'b1};
        tbl[7]  = '{10'h300, D - 1, 1'b0, 4'd0, 1'b0};
        tbl[8]  = '{10'h040, 1,     1'b0, 4'd0, 1'b0};
        tbl[9]  = '{10'h3FF, D + 2, 1'b0, 4'd0, 1'b1};
        tbl[10] = '{10'h080, D,     1'b1, 4'd7, 1'b0};
        tbl[11] = '{10'h020, D,     1'b1, 4'd5, 1'b0};

        // Reset with a key held, then the same key is a fresh press.
        dec_in = 10'h008;
        repeat (3) step();
        @(negedge clk);
        check("rst_bcd_out", bcd_out, 0);
        check("rst_valid", bcd_valid, 0);
        check("rst_key_error", key_error, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", fifo_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (bcd_valid) break;
        end
        check("rst_press_latency", n, D + 3);
        check("rst_press_digit", bcd_out, 3);
        check("rst_press_count", fifo_count, 1);
        dec_in = '0;
        repeat (D + 3) step();
        popped.delete();
        pop_one();
        check("rst_press_pops", popped.size(), 1);
        check("rst_press_valid_after_pop", bcd_valid, 0);

        // Long hold with back-pressure: one digit only.
        press(10'h080, 20, D + 3);
        check("hold_count", fifo_count, 1);
        check("hold_digit", bcd_out, 7);
        check("hold_valid", bcd_valid, 1);
        popped.delete();
        pop_one();
        check("hold_pop_n", popped.size(), 1);
        if (popped.size() > 0) check("hold_pop_val", popped[0], 7);
        check("hold_valid_after", bcd_valid, 0);

        // Glitch, then multi-key fault that persists until a stable release.
        press(10'h020, D - 1, D + 3);
        check("glitch_count", fifo_count, 0);
        e0 = err_seen;
        dec_in = 10'h021;
        repeat (20) step();
        check("multi_err", err_seen - e0, 1);
        check("multi_count", fifo_count, 0);
        dec_in = 10'h001;
        repeat (20) step();
        check("fault_ignore_key", fifo_count, 0);
        dec_in = '0;
        repeat (D - 1) step();
        dec_in = 10'h001;
        repeat (20) step();
        check("fault_short_release", fifo_count, 0);
        check("fault_err_once", err_seen - e0, 1);
        dec_in = '0;
        repeat (D + 3) step();
        press(10'h001, D, D + 3);
        check("fault_recovered_count", fifo_count, 1);
        check("fault_recovered_digit", bcd_out, 0);
        pop_one();

        // Overflow: six presses into a depth-4 FIFO.
        o0 = ovf_seen;
        for (int d = 1; d <= 6; d++) press(10'd1 << d, D + 1, D + 2);
        check("ovf_pulses", ovf_seen - o0, 2);
        check("ovf_count", fifo_count, 4);
        popped.delete();
        bcd_ready = 1'b1;
        repeat (6) step();
        bcd_ready = 1'b0;
        check("ovf_drain_n", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) check("ovf_drain_order", popped[i], i + 1);

        // Push and pop on the same edge while full.
        for (int d = 1; d <= 4; d++) press(10'd1 << d, D, D + 1);
        check("full_count", fifo_count, 4);
        popped.delete();
        o0 = ovf_seen;
        dec_in = 10'h200;
        repeat (D + 2) step();
        bcd_ready = 1'b1;
        step();
        bcd_ready = 1'b0;
        check("pushpop_count", fifo_count, 4);
        check("pushpop_pops", popped.size(), 1);
        repeat (5) step();
        dec_in = '0;
        repeat (D + 3) step();
        check("pushpop_no_ovf", ovf_seen - o0, 0);
        check("pushpop_count_stable", fifo_count, 4);
        bcd_ready = 1'b1;
        repeat (6) step();
        bcd_ready = 1'b0;
        check("pushpop_drain_n", popped.size(), 5);
        if (popped.size() == 5) begin
            check("pushpop_first", popped[0], 1);
            check("pushpop_last", popped[4], 9);
        end

        // Reset with digits queued and a key settling.
        for (int d = 1; d <= 3; d++) press(10'd1 << d, D, D + 1);
        check("midrst_pre_count", fifo_count, 3);
        e0 = err_seen;
        dec_in = 10'h020;
        repeat (3) step();
        rst_n = 1'b0;
        dec_in = '0;
        step();
        check("midrst_count", fifo_count, 0);
        check("midrst_valid", bcd_valid, 0);
        check("midrst_bcd_out", bcd_out, 0);
        step();
        rst_n = 1'b1;
        repeat (3 * D + 6) step();
        check("midrst_no_stale", fifo_count, 0);
        check("midrst_no_err", err_seen - e0, 0);

        // Vector table.
        foreach (tbl[k]) begin
            e0 = err_seen;
            press(tbl[k].vec, tbl[k].hold, D + 3);
            check($sformatf("tbl%0d_count", k), fifo_count, {31'd0, tbl[k].exp_push});
            if (tbl[k].exp_push) check($sformatf("tbl%0d_digit", k), bcd_out, tbl[k].exp_bcd);
            check($sformatf("tbl%0d_err", k), err_seen - e0, {31'd0, tbl[k].exp_err});
            if (fifo_count != 0) pop_one();
        end

        // Random presses vs. a press-level model: a press counts once it is held
        // for D samples; one key gives its index, several keys give an error.
        popped.delete();
        exp_err = 0;
        e0 = err_seen;
        o0 = ovf_seen;
        rand_ready = 1;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) < 7) begin
                v = 10'd1 << $urandom_range(0, 9);
            end else begin
                v = 10'($urandom);
                while ($countones(v) < 2) v = 10'($urandom);
            end
            h = $urandom_range(1, 2 * D + 3);
            if (h >= D) begin
                if ($countones(v) == 1) exp_q.push_back(4'($clog2(v)));
                else exp_err++;
            end
            press(v, h, $urandom_range(D, D + 4));
        end
        rand_ready = 0;
        bcd_ready = 1'b1;
        repeat (12) step();
        bcd_ready = 1'b0;
        check("rand_n_digits", popped.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
            check($sformatf("rand_digit%0d", i), popped[i], exp_q[i]);
        check("rand_errors", err_seen - e0, exp_err);
        check("rand_no_ovf", ovf_seen - o0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
